// File: rtl/cpu15_pkg.sv
// ---------------------------------------------------------------------------
// cpu15_pkg
// Shared CPU definitions for the write-back stage: the default register file
// geometry and the word / index types that match that default geometry.
// No ports; imported by reg_sb and reg_file_sb.
// ---------------------------------------------------------------------------
package cpu15_pkg;

  localparam int CPU15_DATA_W = 16;
  localparam int CPU15_N_REGS = 8;
  localparam int CPU15_ADDR_W = $clog2(CPU15_N_REGS);

  typedef logic [CPU15_DATA_W-1:0] reg_word_t;
  typedef logic [CPU15_ADDR_W-1:0] reg_idx_t;

endpackage : cpu15_pkg

// File: rtl/reg_sb.sv
// ---------------------------------------------------------------------------
// reg_sb
// Pending-write scoreboard: one busy bit per register. Issue sets a bit and
// write-back clears it. When both hit the same index on one edge, the set
// wins because a newer producer has just been issued.
//
// Ports:
//   clk      - write-back clock, rising edge
//   rst_n    - asynchronous active-low reset, clears every busy bit
//   set_en   - mark register set_idx busy
//   set_idx  - register index to mark busy
//   clr_en   - write-back completed for register clr_idx
//   clr_idx  - register index to clear
//   busy_vec - bit i set while register i has a pending write
// ---------------------------------------------------------------------------
module reg_sb
  import cpu15_pkg::*;
#(
  parameter int N_REGS = CPU15_N_REGS,
  localparam int ADDR_W = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  output logic [N_REGS-1:0] busy_vec
);

  logic [N_REGS-1:0] busy_q;
  logic [N_REGS-1:0] busy_next;

  // Clear is applied first so that a set to the same index overrides it.
  always_comb begin
    busy_next = busy_q;
    if (clr_en) busy_next[clr_idx] = 1'b0;
    if (set_en) busy_next[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_next;
  end

  assign busy_vec = busy_q;

endmodule : reg_sb

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// Parametrised write-back register file with a per-register busy scoreboard
// for RAW hazard detection. One synchronous write port, two combinational
// read ports.
//
// Optional feature macro: REG_FILE_BYPASS_EN
//   defined   - a read hitting the register being written this cycle returns
//               REG_IN, and its busy flag reads as already cleared (unless
//               the same register is being re-marked busy this cycle).
//   undefined - reads return stored state only; new data and the cleared
//               busy bit appear after the write edge.
//
// Ports:
//   CLK_WB            - write-back clock, all state updates on rising edge
//   RESET_N           - asynchronous active-low reset
//   REG_WEN           - write enable
//   N_REG, REG_IN     - write destination index and data
//   BUSY_SET, BUSY_N  - mark register BUSY_N as pending
//   RA_A, RA_B        - read addresses
//   RD_A, RD_B        - read data (combinational)
//   BUSY_A, BUSY_B    - busy status of RA_A / RA_B (combinational)
//   BUSY_VEC          - bit i = register i busy
//   REG_FLAT          - all registers, register i at [i*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module reg_file_sb
  import cpu15_pkg::*;
#(
  parameter int DATA_W  = CPU15_DATA_W,
  parameter int N_REGS  = CPU15_N_REGS,
  parameter int ZERO_R0 = 0,
  localparam int ADDR_W = $clog2(N_REGS)
) (
  input  logic                     CLK_WB,
  input  logic                     RESET_N,
  input  logic                     REG_WEN,
  input  logic [ADDR_W-1:0]        N_REG,
  input  logic [DATA_W-1:0]        REG_IN,
  input  logic                     BUSY_SET,
  input  logic [ADDR_W-1:0]        BUSY_N,
  input  logic [ADDR_W-1:0]        RA_A,
  input  logic [ADDR_W-1:0]        RA_B,
  output logic [DATA_W-1:0]        RD_A,
  output logic [DATA_W-1:0]        RD_B,
  output logic                     BUSY_A,
  output logic                     BUSY_B,
  output logic [N_REGS-1:0]        BUSY_VEC,
  output logic [N_REGS*DATA_W-1:0] REG_FLAT
);

  logic [DATA_W-1:0] regs [N_REGS];
  logic [N_REGS-1:0] busy_vec;
  logic              wr_ok;
  logic              set_ok;

  // With a hardwired R0, writes and busy marks aimed at index 0 are dropped
  // here so neither the data array nor the scoreboard ever sees them.
  assign wr_ok  = REG_WEN  && !((ZERO_R0 != 0) && (N_REG  == '0));
  assign set_ok = BUSY_SET && !((ZERO_R0 != 0) && (BUSY_N == '0));

  always_ff @(posedge CLK_WB or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[N_REG] <= REG_IN;
    end
  end

  reg_sb #(
    .N_REGS (N_REGS)
  ) u_reg_sb (
    .clk      (CLK_WB),
    .rst_n    (RESET_N),
    .set_en   (set_ok),
    .set_idx  (BUSY_N),
    .clr_en   (wr_ok),
    .clr_idx  (N_REG),
    .busy_vec (busy_vec)
  );

  logic [ADDR_W-1:0] ra      [2];
  logic [DATA_W-1:0] rd      [2];
  logic              busy_rd [2];

  assign ra[0] = RA_A;
  assign ra[1] = RA_B;

  // Read muxes. The reset gate matters only for the bypass path, since the
  // stored state is already cleared asynchronously, but it keeps every read
  // output at zero for as long as reset is held.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p]      = regs[ra[p]];
      busy_rd[p] = busy_vec[ra[p]];
`ifdef REG_FILE_BYPASS_EN
      if (wr_ok && (N_REG == ra[p])) begin
        rd[p]      = REG_IN;
        busy_rd[p] = set_ok && (BUSY_N == ra[p]);
      end
`endif
      if (!RESET_N || ((ZERO_R0 != 0) && (ra[p] == '0))) begin
        rd[p]      = '0;
        busy_rd[p] = 1'b0;
      end
    end
  end

  assign RD_A     = rd[0];
  assign RD_B     = rd[1];
  assign BUSY_A   = busy_rd[0];
  assign BUSY_B   = busy_rd[1];
  assign BUSY_VEC = busy_vec;

  for (genvar g = 0; g < N_REGS; g++) begin : g_flat
    assign REG_FLAT[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
// Bench for reg_file_sb. Two instances share one stimulus stream: dut0 with
// ZERO_R0=0 and dut1 with ZERO_R0=1. Follows REG_FILE_BYPASS_EN the same way
// the design does, so the reference model matches whichever build is chosen.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;
  import cpu15_pkg::*;

  // Inputs shared by both instances
  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      wen = 1'b0;
  logic      bset = 1'b0;
  reg_idx_t  n_reg = '0;
  reg_idx_t  busy_n = '0;
  reg_idx_t  ra_a = '0;
  reg_idx_t  ra_b = '0;
  reg_word_t reg_in = '0;

  reg_word_t     rd_a [2];
  reg_word_t     rd_b [2];
  logic          busy_a [2];
  logic          busy_b [2];
  logic [7:0]    bvec [2];
  logic [127:0]  flat [2];

  reg_file_sb #(.DATA_W(16), .N_REGS(8), .ZERO_R0(0)) dut0 (
    .CLK_WB(clk), .RESET_N(rst_n), .REG_WEN(wen), .N_REG(n_reg), .REG_IN(reg_in),
    .BUSY_SET(bset), .BUSY_N(busy_n), .RA_A(ra_a), .RA_B(ra_b),
    .RD_A(rd_a[0]), .RD_B(rd_b[0]), .BUSY_A(busy_a[0]), .BUSY_B(busy_b[0]),
    .BUSY_VEC(bvec[0]), .REG_FLAT(flat[0])
  );

  reg_file_sb #(.DATA_W(16), .N_REGS(8), .ZERO_R0(1)) dut1 (
    .CLK_WB(clk), .RESET_N(rst_n), .REG_WEN(wen), .N_REG(n_reg), .REG_IN(reg_in),
    .BUSY_SET(bset), .BUSY_N(busy_n), .RA_A(ra_a), .RA_B(ra_b),
    .RD_A(rd_a[1]), .RD_B(rd_b[1]), .BUSY_A(busy_a[1]), .BUSY_B(busy_b[1]),
    .BUSY_VEC(bvec[1]), .REG_FLAT(flat[1])
  );

  // Free-running write-back clock, rising edges at 5, 15, 25, ...
  initial forever #5 clk = ~clk;

  typedef struct {
    reg_word_t    rd_a;
    reg_word_t    rd_b;
    logic         busy_a;
    logic         busy_b;
    logic [7:0]   bvec;
    logic [127:0] flat;
  } exp_t;

  exp_t sb_q0[$];
  exp_t sb_q1[$];

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: architectural register contents and pending flags
  reg_word_t m_mem  [2][8];
  logic      m_busy [2][8];

  function automatic logic zeroed(int k, reg_idx_t a);
    return (k == 1) && (a == 0);
  endfunction

  function automatic reg_word_t m_read(int k, reg_idx_t a);
    if (!rst_n || zeroed(k, a)) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (wen && n_reg == a) return reg_in;
`endif
    return m_mem[k][a];
  endfunction

  function automatic logic m_busy_rd(int k, reg_idx_t a);
    if (!rst_n || zeroed(k, a)) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if (wen && n_reg == a) return bset && (busy_n == a);
`endif
    return m_busy[k][a];
  endfunction

  function automatic exp_t m_expect(int k);
    exp_t e;
    e.rd_a   = m_read(k, ra_a);
    e.rd_b   = m_read(k, ra_b);
    e.busy_a = m_busy_rd(k, ra_a);
    e.busy_b = m_busy_rd(k, ra_b);
    e.bvec   = '0;
    e.flat   = '0;
    for (int i = 0; i < 8; i++) begin
      e.bvec[i]         = m_busy[k][i];
      e.flat[i*16 +: 16] = m_mem[k][i];
    end
    return e;
  endfunction

  task automatic m_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) begin
        m_mem[k][i]  = '0;
        m_busy[k][i] = 1'b0;
      end
  endtask

  // Effect of one rising edge: write-back retires first, then a new issue
  // to the same register re-marks it busy.
  task automatic m_edge();
    for (int k = 0; k < 2; k++) begin
      if (wen && !zeroed(k, n_reg)) begin
        m_mem[k][n_reg]  = reg_in;
        m_busy[k][n_reg] = 1'b0;
      end
      if (bset && !zeroed(k, busy_n)) m_busy[k][busy_n] = 1'b1;
    end
  endtask

  // Drive one cycle of inputs just after the falling edge. A low reset takes
  // effect immediately (between edges), so the model is cleared at once.
  task automatic apply_stimulus(input logic r, input logic w, input reg_idx_t n,
                                input reg_word_t d, input logic s, input reg_idx_t bn,
                                input reg_idx_t a, input reg_idx_t b);
    @(negedge clk);
    rst_n  = r;
    wen    = w;
    n_reg  = n;
    reg_in = d;
    bset   = s;
    busy_n = bn;
    ra_a   = a;
    ra_b   = b;
    if (!r) m_clear();
    #1;
    sb_q0.push_back(m_expect(0));
    sb_q1.push_back(m_expect(1));
    if (r) m_edge();
  endtask

  task automatic check_output(input string name, input int inst,
                              input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s dut%0d t=%0t got %h expected %h", name, inst, $time, act, exp);
    end
  endtask

  task automatic compare(input int k, input exp_t e);
    check_output("rd_a",     k, 128'(rd_a[k]),   128'(e.rd_a));
    check_output("rd_b",     k, 128'(rd_b[k]),   128'(e.rd_b));
    check_output("busy_a",   k, 128'(busy_a[k]), 128'(e.busy_a));
    check_output("busy_b",   k, 128'(busy_b[k]), 128'(e.busy_b));
    check_output("busy_vec", k, 128'(bvec[k]),   128'(e.bvec));
    check_output("reg_flat", k, flat[k],         e.flat);
  endtask

  // Monitor: outputs are valid every cycle; sample 2 time units after the
  // falling edge, well after stimulus settles and away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q0.size() > 0) begin
        e = sb_q0.pop_front();
        compare(0, e);
      end
      if (sb_q1.size() > 0) begin
        e = sb_q1.pop_front();
        compare(1, e);
      end
    end
  end

  initial begin
    m_clear();
    $display("[TB] start");

    // Reset held for two cycles, then idle
    apply_stimulus(0, 0, 0, 16'h0000, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 16'h0000, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 16'h0000, 0, 0, 0, 0);

    // Basic write and disabled write
    apply_stimulus(1, 1, 1, 16'hBEAF, 0, 0, 1, 0);
    apply_stimulus(1, 0, 2, 16'h5555, 0, 0, 1, 2);
    apply_stimulus(1, 0, 0, 16'h0000, 0, 0, 1, 2);

    // Scoreboard set, clear, and same-cycle set + write-back
    apply_stimulus(1, 0, 0, 16'h0000, 1, 3, 3, 0);
    apply_stimulus(1, 0, 0, 16'h0000, 0, 0, 3, 0);
    apply_stimulus(1, 1, 3, 16'h1234, 0, 0, 3, 3);
    apply_stimulus(1, 0, 0, 16'h0000, 0, 0, 3, 3);
    apply_stimulus(1, 1, 3, 16'h1234, 1, 3, 3, 3);
    apply_stimulus(1, 0, 0, 16'h0000, 0, 0, 3, 3);

    // Read port B on the register being written
    apply_stimulus(1, 1, 5, 16'hCAFE, 0, 0, 0, 5);
    apply_stimulus(1, 0, 0, 16'h0000, 0, 0, 0, 5);

    // Fill R4..R7, mark R6 busy, then reset mid-sequence with a write pending
    for (int i = 4; i < 8; i++)
      apply_stimulus(1, 1, reg_idx_t'(i), 16'hBEAF, (i == 7), 6, 4, 6);
    apply_stimulus(1, 0, 0, 16'h0000, 0, 0, 6, 7);
    apply_stimulus(0, 1, 4, 16'h7777, 1, 4, 4, 6);
    apply_stimulus(0, 1, 4, 16'h7777, 0, 0, 4, 6);
    apply_stimulus(1, 0, 0, 16'h0000, 0, 0, 4, 6);

    // Register 0 write and busy mark (dropped only on the hardwired-R0 instance)
    apply_stimulus(1, 1, 0, 16'hFFFF, 1, 0, 0, 0);
    apply_stimulus(1, 0, 0, 16'h0000, 0, 0, 0, 1);

    // Randomized traffic with frequent index collisions and occasional reset
    for (int c = 0; c < 400; c++) begin
      logic      r, w, s;
      reg_idx_t  n, bn, a, b;
      reg_word_t d;
      r  = ($urandom_range(0, 29) != 0);
      w  = $urandom_range(0, 1) == 1;
      s  = $urandom_range(0, 2) == 0;
      n  = reg_idx_t'($urandom_range(0, 7));
      bn = ($urandom_range(0, 3) == 0) ? n : reg_idx_t'($urandom_range(0, 7));
      a  = ($urandom_range(0, 2) == 0) ? n : reg_idx_t'($urandom_range(0, 7));
      b  = ($urandom_range(0, 2) == 0) ? bn : reg_idx_t'($urandom_range(0, 7));
      d  = reg_word_t'($urandom());
      apply_stimulus(r, w, n, d, s, bn, a, b);
    end

    // Let the monitor drain, then confirm nothing was left unchecked
    repeat (2) @(negedge clk);
    #3;
    check_output("drain", 0, 128'(sb_q0.size()), 128'(0));
    check_output("drain", 1, 128'(sb_q1.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_reg_file_sb

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised write-back register file with per-register busy scoreboard, the next-generation replacement for the fixed 8×16 write-back register block in the CPU write-back stage. It holds `N_REGS` registers of `DATA_W` bits and provides:

- one synchronous write port;
- two combinational read ports with optional same-cycle write bypass;
- a pending-write scoreboard that the issue logic sets and write-back clears, for RAW hazard detection.

## Interface
Parameters:
- `DATA_W`, 16, register width in bits.
- `N_REGS`, 8, number of registers; power of two, at least 2.
- `ZERO_R0`, 0, when 1 register 0 is hardwired to zero, ignores writes and is never busy.
- `ADDR_W`, `$clog2(N_REGS)`, derived localparam; not overridable.

Ports:
- `CLK_WB` in 1: write-back clock; all state updates on its rising edge.
- `RESET_N` in 1: reset, asynchronous, active-low.
- `REG_WEN` in 1: write enable for the write-back port.
- `N_REG` in `ADDR_W`: write-back destination register index.
- `REG_IN` in `DATA_W`: write-back data.
- `BUSY_SET` in 1: issue marks register `BUSY_N` as pending.
- `BUSY_N` in `ADDR_W`: register index to mark busy.
- `RA_A`, `RA_B` in `ADDR_W`: read addresses, ports A and B.
- `RD_A`, `RD_B` out `DATA_W`: read data, combinational.
- `BUSY_A`, `BUSY_B` out 1: busy status of `RA_A` / `RA_B`, combinational.
- `BUSY_VEC` out `N_REGS`: bit i = register i busy.
- `REG_FLAT` out `N_REGS*DATA_W`: all registers; register i at `[i*DATA_W +: DATA_W]`.

## Operation
- Write: on `CLK_WB` rising edge with `REG_WEN`=1, `REG[N_REG]` <= `REG_IN`, and `busy[N_REG]` is cleared. With `REG_WEN`=0, nothing is written.
- Busy set: on the edge with `BUSY_SET`=1, `busy[BUSY_N]` <= 1.
- Simultaneous set and write-back, same index: set wins. The data is written, and busy stays 1 because a newer producer has been issued.
- Simultaneous set and write-back, different indices: both take effect.
- `ZERO_R0`=1:
  - writes to index 0 are dropped;
  - `BUSY_SET` to index 0 is ignored;
  - reads of index 0 return 0, and `BUSY_A`/`BUSY_B` for index 0 are 0;
  - `REG_FLAT` slot 0 is 0.
- Reads: `RD_A` = `REG[RA_A]` and `RD_B` = `REG[RA_B]`, combinationally, plus bypass when enabled (see Configuration).
- Reset: asserting `RESET_N`=0 at any time, including mid-sequence, immediately clears every register and every busy bit. While in reset:
  - `RD_A`, `RD_B` and `REG_FLAT` are 0;
  - `BUSY_A`, `BUSY_B` and `BUSY_VEC` are 0.
- Writes and busy sets asserted during reset are discarded. The first update takes place on the first rising edge after `RESET_N` deasserts.

## Timing
- Write latency: 1 cycle. The data is visible in `REG_FLAT` and in non-bypassed reads after the edge.
- Busy set: `BUSY_VEC` bit goes high after the edge following `BUSY_SET`.
- Busy clear: `BUSY_VEC` bit goes low after the write-back edge.
- Read ports have zero-cycle latency; no handshake.
- Out-of-range indices cannot occur because `N_REGS` is a power of two.

## Configuration
- Macro: `REG_FILE_BYPASS_EN`.
- Defined:
  - when `REG_WEN`=1 and `N_REG`=`RA_x` (and not the zeroed R0), `RD_x` = `REG_IN` in the same cycle;
  - `BUSY_x` reads 0 in that cycle, unless `BUSY_SET` targets the same index in that cycle.
- Undefined:
  - `RD_x` returns the stored value;
  - `BUSY_x` reflects the stored busy bit only;
  - the new value and cleared busy bit appear one cycle later.

## Structure
- Shared package `cpu15_pkg`: default `DATA_W`/`N_REGS` constants, a `reg_idx_t` typedef and a `reg_word_t` typedef.
- One sub-module, `reg_sb`:
  - holds the busy-bit array with set/clear priority and async reset;
  - `reg_file_sb` instantiates it next to the data array and read muxes.

## Test plan
- Reset then idle: `RESET_N`=0 for 2 cycles, then 1 → `REG_FLAT`=0, `BUSY_VEC`=0.
- Basic write: `REG_WEN`=1, `N_REG`=1, `REG_IN`=16'hBEAF → after the edge, `REG_FLAT[31:16]`=BEAF; with `RA_A`=1, `RD_A`=BEAF. With `REG_WEN`=0, `N_REG`=2 → REG2 stays 0.
- Scoreboard:
  - `BUSY_SET` to index 3 → `BUSY_VEC`=8'h08 and `BUSY_A`=1 (`RA_A`=3);
  - write-back of 16'h1234 to 3 → `BUSY_VEC`=0.
  - Set and write-back to index 3 in the same cycle → busy stays 1, REG3=1234.
- Bypass (defined): `RA_B`=5, write 16'hCAFE to 5 → `RD_B`=CAFE in the same cycle.
- Bypass (undefined): same stimulus → `RD_B`=old value, then CAFE next cycle.
- Mid-operation reset:
  - fill R4..R7 with BEAF and set busy on 6;
  - assert `RESET_N`=0 asynchronously between edges → all outputs 0 immediately;
  - `REG_WEN` during reset → no write.
- `ZERO_R0`=1: write 16'hFFFF to 0 and `BUSY_SET` to 0 → `RD_A`=0 (`RA_A`=0), `BUSY_VEC`[0]=0.
